// File: rtl/ct_div_param_if.sv
// Handshake and operand/result bundle for the ct_div_param sequential divider.
// The requester uses the master modport and the divider uses the slave modport.
interface ct_div_param_if #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned FRAC  = 25
);
    localparam int unsigned QW = WIDTH + FRAC;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [QW-1:0]    quotient;
    logic [WIDTH-1:0] remainder;
    logic             dz;
    logic             ovf;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, dz, ovf
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, dz, ovf
    );
endinterface

// File: rtl/ct_div_param.sv
// Sequential shift/subtract divider producing one quotient bit per clock.
// Handles unsigned and signed operands; results hold until the next accepted start.
module ct_div_param #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned FRAC  = 25
) (
    input logic           clk,
    input logic           reset_n,
    ct_div_param_if.slave bus
);
    localparam int unsigned QW = WIDTH + FRAC;
    localparam int unsigned CW = $clog2(QW + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] ITER = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic             nneg_q, nneg_d;
    logic             qneg_q, qneg_d;
    logic [QW-1:0]    sh_q, sh_d;
    logic [QW-1:0]    quot_q, quot_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [QW-1:0]    qout_q, qout_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   ptmp;
    logic             ge;
    logic [WIDTH-1:0] nmag;
    logic             n_neg, d_neg, ovf_case;

    always_comb begin
        state_d  = state_q;
        sgn_d    = sgn_q;
        n_d      = n_q;
        d_d      = d_q;
        dmag_d   = dmag_q;
        part_d   = part_q;
        nneg_d   = nneg_q;
        qneg_d   = qneg_q;
        sh_d     = sh_q;
        quot_d   = quot_q;
        cnt_d    = cnt_q;
        qout_d   = qout_q;
        rout_d   = rout_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        n_neg    = sgn_q & n_q[WIDTH-1];
        d_neg    = sgn_q & d_q[WIDTH-1];
        nmag     = n_neg ? -n_q : n_q;
        // Partial remainder is kept below |D|, so only the shifted value needs the extra bit.
        ptmp     = {part_q, sh_q[QW-1]};
        ge       = (ptmp >= {1'b0, dmag_q});
        ovf_case = sgn_q && (n_q == {1'b1, {(WIDTH-1){1'b0}}}) && (d_q == '1);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sgn_d   = bus.is_signed;
                    n_d     = bus.dividend;
                    d_d     = bus.divisor;
                    state_d = PREP;
                end
            end
            PREP: begin
                ovf_d = 1'b0;
                if (d_q == '0) begin
                    qout_d  = '1;
                    rout_d  = n_q;
                    dz_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    dz_d    = 1'b0;
                    dmag_d  = d_neg ? -d_q : d_q;
                    nneg_d  = n_neg;
                    qneg_d  = n_neg ^ d_neg;
                    part_d  = '0;
                    quot_d  = '0;
                    sh_d    = QW'(nmag) << FRAC;
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                sh_d   = sh_q << 1;
                part_d = ge ? WIDTH'(ptmp - {1'b0, dmag_q}) : ptmp[WIDTH-1:0];
                quot_d = {quot_q[QW-2:0], ge};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(QW - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (ovf_case) begin
                    qout_d = {1'b0, {(QW-1){1'b1}}};
                    rout_d = '0;
                    ovf_d  = 1'b1;
                end else begin
                    qout_d = qneg_q ? -quot_q : quot_q;
                    rout_d = nneg_q ? -part_q : part_q;
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
            n_q     <= '0;
            d_q     <= '0;
            dmag_q  <= '0;
            part_q  <= '0;
            nneg_q  <= 1'b0;
            qneg_q  <= 1'b0;
            sh_q    <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            qout_q  <= '0;
            rout_q  <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            n_q     <= n_d;
            d_q     <= d_d;
            dmag_q  <= dmag_d;
            part_q  <= part_d;
            nneg_q  <= nneg_d;
            qneg_q  <= qneg_d;
            sh_q    <= sh_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.quotient  = qout_q;
    assign bus.remainder = rout_q;
    assign bus.dz        = dz_q;
    assign bus.ovf       = ovf_q;
endmodule
